// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for an 8-digit common-anode 7-segment display.
// Inputs are snapshotted once per frame; each digit slot is a blanking gap followed by a drive window.
module display_scan_ctrl #(
    parameter int unsigned DRIVE_CYCLES = 99000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] hex_word,
    input  logic [7:0]  digit_en,
    input  logic [7:0]  dp_en,
    output logic [6:0]  segments,
    output logic        dp,
    output logic [7:0]  anodos,
    output logic        frame_done
);

    localparam int unsigned MAXC = (DRIVE_CYCLES > BLANK_CYCLES) ? DRIVE_CYCLES : BLANK_CYCLES;
    localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] DRIVE_LAST = CW'(DRIVE_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } state_e;

    state_e          state_q;
    logic [2:0]      idx_q;
    logic [CW-1:0]   cnt_q;
    logic [31:0]     hex_q;
    logic [7:0]      en_q;
    logic [7:0]      dpen_q;

    logic [6:0]      seg_q,  seg_d;
    logic            dp_q,   dp_d;
    logic [7:0]      an_q,   an_d;
    logic            fd_q,   fd_d;
    logic [3:0]      nib;

    function automatic logic [6:0] decode_hex(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'b0000001;
            4'h1:    s = 7'b1001111;
            4'h2:    s = 7'b0010010;
            4'h3:    s = 7'b0000110;
            4'h4:    s = 7'b1001100;
            4'h5:    s = 7'b0100100;
            4'h6:    s = 7'b0100000;
            4'h7:    s = 7'b0001111;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0000100;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b1100000;
            4'hC:    s = 7'b0110001;
            4'hD:    s = 7'b1000010;
            4'hE:    s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    assign nib = hex_q[{idx_q, 2'b00} +: 4];

    // Output registers capture the state executing at each edge, so the pins
    // show exactly one cycle of LOAD, then BLANK_CYCLES dark, then the drive window.
    always_comb begin
        seg_d = '1;
        dp_d  = 1'b1;
        an_d  = '1;
        fd_d  = 1'b0;
        case (state_q)
            ST_LOAD: fd_d = 1'b1;
            ST_DRIVE: begin
                if (en_q[idx_q]) begin
                    an_d  = ~(8'b1 << idx_q);
                    seg_d = decode_hex(nib);
                    dp_d  = ~dpen_q[idx_q];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_LOAD;
            idx_q   <= '0;
            cnt_q   <= '0;
            hex_q   <= '0;
            en_q    <= '0;
            dpen_q  <= '0;
            seg_q   <= '1;
            dp_q    <= 1'b1;
            an_q    <= '1;
            fd_q    <= 1'b0;
        end else begin
            seg_q <= seg_d;
            dp_q  <= dp_d;
            an_q  <= an_d;
            fd_q  <= fd_d;
            case (state_q)
                ST_LOAD: begin
                    hex_q   <= hex_word;
                    en_q    <= digit_en;
                    dpen_q  <= dp_en;
                    idx_q   <= '0;
                    cnt_q   <= '0;
                    state_q <= ST_BLANK;
                end
                ST_BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        cnt_q   <= '0;
                        state_q <= ST_DRIVE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DRIVE: begin
                    if (cnt_q == DRIVE_LAST) begin
                        cnt_q <= '0;
                        if (idx_q == 3'd7) begin
                            state_q <= ST_LOAD;
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            state_q <= ST_BLANK;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= ST_LOAD;
            endcase
        end
    end

    assign segments   = seg_q;
    assign dp         = dp_q;
    assign anodos     = an_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl: per-frame expected pin vectors are queued
// when a frame's stimulus is applied and popped one per clock as the DUT scans.
module tb_display_scan_ctrl;

    localparam int unsigned DRV = 4;
    localparam int unsigned BLK = 2;
    localparam int unsigned S   = DRV + BLK;
    localparam int unsigned FRAME = 1 + 8 * S;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] hex_word;
    logic [7:0]  digit_en;
    logic [7:0]  dp_en;
    logic [6:0]  segments;
    logic        dp;
    logic [7:0]  anodos;
    logic        frame_done;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned frame_no = 0;

    typedef struct {
        string       tag;
        logic [16:0] v;
    } exp_t;
    exp_t sb[$];

    logic [6:0] seg_tab [16];

    display_scan_ctrl #(.DRIVE_CYCLES(DRV), .BLANK_CYCLES(BLK)) dut (
        .clock      (clock),
        .reset      (reset),
        .hex_word   (hex_word),
        .digit_en   (digit_en),
        .dp_en      (dp_en),
        .segments   (segments),
        .dp         (dp),
        .anodos     (anodos),
        .frame_done (frame_done)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [16:0] obs, input logic [16:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got fd=%b an=%h seg=%b dp=%b, want fd=%b an=%h seg=%b dp=%b",
                     tag, obs[16], obs[15:8], obs[7:1], obs[0],
                     exp[16], exp[15:8], exp[7:1], exp[0]);
        end
    endtask

    function automatic logic [16:0] pins();
        return {frame_done, anodos, segments, dp};
    endfunction

    // Expected pins for frame cycle c (c=0 is the LOAD cycle).
    function automatic logic [16:0] model(input int unsigned c, input logic [31:0] hx,
                                          input logic [7:0] en, input logic [7:0] dpe);
        int unsigned k, slot, ph;
        logic [3:0] n;
        if (c == 0) return {1'b1, 8'hFF, 7'h7F, 1'b1};
        k = c - 1;
        slot = k / S;
        ph = k % S;
        if (ph < BLK || !en[slot]) return {1'b0, 8'hFF, 7'h7F, 1'b1};
        n = hx[slot*4 +: 4];
        return {1'b0, ~(8'b1 << slot), seg_tab[n], ~dpe[slot]};
    endfunction

    // Drive one frame's inputs, queue its expectations and compare the first
    // n_cyc cycles; optionally change hex_word after cycle chg_at.
    task automatic run_frame(input logic [31:0] hx, input logic [7:0] en, input logic [7:0] dpe,
                             input int unsigned n_cyc, input int chg_at, input logic [31:0] hx_chg);
        exp_t e;
        hex_word = hx;
        digit_en = en;
        dp_en    = dpe;
        for (int unsigned c = 0; c < FRAME; c++) begin
            e.tag = $sformatf("frame%0d_cyc%0d", frame_no, c);
            e.v   = model(c, hx, en, dpe);
            sb.push_back(e);
        end
        for (int unsigned c = 0; c < n_cyc; c++) begin
            @(posedge clock);
            #1;
            e = sb.pop_front();
            check_eq(e.tag, pins(), e.v);
            if (int'(c) == chg_at) hex_word = hx_chg;
        end
        sb.delete();
        frame_no++;
    endtask

    initial begin
        seg_tab[0]  = 7'b0000001; seg_tab[1]  = 7'b1001111;
        seg_tab[2]  = 7'b0010010; seg_tab[3]  = 7'b0000110;
        seg_tab[4]  = 7'b1001100; seg_tab[5]  = 7'b0100100;
        seg_tab[6]  = 7'b0100000; seg_tab[7]  = 7'b0001111;
        seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0000100;
        seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b1100000;
        seg_tab[12] = 7'b0110001; seg_tab[13] = 7'b1000010;
        seg_tab[14] = 7'b0110000; seg_tab[15] = 7'b0111000;

        reset    = 1'b0;
        hex_word = 32'h76543210;
        digit_en = 8'hFF;
        dp_en    = 8'h00;
        repeat (3) begin
            @(posedge clock);
            #1;
            check_eq("in_reset", pins(), {1'b0, 8'hFF, 7'h7F, 1'b1});
        end
        @(negedge clock);
        reset = 1'b1;

        // First frame after release, then decode sweep and DP pattern
        run_frame(32'h76543210, 8'hFF, 8'h00, FRAME, -1, 32'h0);
        run_frame(32'hFEDCBA98, 8'hFF, 8'h81, FRAME, -1, 32'h0);

        // Coherency: hex changes during digit 3's drive window
        run_frame(32'h00000000, 8'hFF, 8'h00, FRAME, int'(1 + 3*S + BLK + 1), 32'hFFFFFFFF);
        run_frame(32'hFFFFFFFF, 8'hFF, 8'h00, FRAME, -1, 32'h0);

        // Masking and all-disabled frames
        run_frame(32'h89ABCDEF, 8'b0000_0101, 8'b0000_0100, FRAME, -1, 32'h0);
        run_frame(32'h12345678, 8'h00, 8'hFF, FRAME, -1, 32'h0);
        run_frame(32'h12345678, 8'h00, 8'hFF, FRAME, -1, 32'h0);

        // Reset while digit 5 is lit
        run_frame(32'h0F0F0F0F, 8'hFF, 8'h20, 1 + 5*S + BLK + 2, -1, 32'h0);
        #2;
        reset = 1'b0;
        #1;
        check_eq("async_reset_dark", pins(), {1'b0, 8'hFF, 7'h7F, 1'b1});
        @(negedge clock);
        reset = 1'b1;
        run_frame(32'hA5A5A5A5, 8'hFF, 8'h01, FRAME, -1, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
